// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the integer ALU issue queue: operand and entry layouts.
// Top-level TAG_W/XLEN parameters must match IQ_TAG_W/IQ_XLEN below.
package alu_iq_pkg;

    localparam int IQ_TAG_W = 6;
    localparam int IQ_XLEN  = 32;

    typedef struct packed {
        logic [IQ_XLEN-1:0]  data;
        logic [IQ_TAG_W-1:0] tag;
        logic                rdy;
    } iq_operand_t;

    typedef struct packed {
        logic                valid;
        iq_operand_t         op1;
        iq_operand_t         op2;
        logic [IQ_TAG_W-1:0] rd_tag;
        logic [2:0]          funct3;
        logic [2:0]          alu_ext;
    } iq_entry_t;

    // An entry can leave the queue once both of its operands hold data
    function automatic logic iq_entry_ready(input iq_entry_t e);
        return e.valid & e.op1.rdy & e.op2.rdy;
    endfunction

endpackage

// File: rtl/alu_issue_queue_wakeup.sv
// One operand's CDB snoop: a pending operand whose tag matches a valid broadcast
// takes the broadcast data and becomes ready. Tag 0 is an ordinary tag.
module iq_operand_wakeup
    import alu_iq_pkg::*;
#(
    parameter int TAG_W = IQ_TAG_W,
    parameter int XLEN  = IQ_XLEN
) (
    input  logic [XLEN-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_rdy,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic [XLEN-1:0]  out_data,
    output logic             out_rdy
);

    logic hit_s;

    assign hit_s = cdb_valid & ~in_rdy & (cdb_tag == in_tag);

    // Select broadcast data on a tag hit, otherwise pass the operand through
    always_comb begin
        out_data = in_data;
        out_rdy  = in_rdy;
        if (hit_s) begin
            out_data = cdb_data;
            out_rdy  = 1'b1;
        end else begin
            out_data = in_data;
            out_rdy  = in_rdy;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Integer ALU reservation station: age-ordered collapsing queue with CDB wakeup
// and oldest-ready issue. Define ALU_IQ_BYPASS_EN for same-cycle dispatch bypass.
module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W,
    parameter int XLEN  = IQ_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             queue_alu_en,
    input  logic [XLEN-1:0]  queue_op1_data,
    input  logic [TAG_W-1:0] queue_op1_tag,
    input  logic             queue_op1_data_valid,
    input  logic [XLEN-1:0]  queue_op2_data,
    input  logic [TAG_W-1:0] queue_op2_tag,
    input  logic             queue_op2_data_valid,
    input  logic [TAG_W-1:0] queue_rd_tag,
    input  logic [2:0]       queue_funct3,
    input  logic [2:0]       queue_alu_ext,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             alu_queue_full,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [XLEN-1:0]  issue_op1,
    output logic [XLEN-1:0]  issue_op2,
    output logic [TAG_W-1:0] issue_rd_tag,
    output logic [2:0]       issue_funct3,
    output logic [2:0]       issue_alu_ext
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        entries_r     [DEPTH];
    iq_entry_t        woken_ext_s   [DEPTH+1];
    iq_entry_t        entries_nxt_s [DEPTH];
    iq_entry_t        disp_entry_s;
    iq_entry_t        sel_entry_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [CNT_W-1:0] wr_idx_s;
    logic [DEPTH-1:0] ready_s;
    logic [IDX_W-1:0] sel_s;
    logic             any_ready_s;
    logic             full_s;
    logic             q_fire_s;
    logic             disp_accept_s;
    logic             disp_write_s;
    logic             bypass_s;

    logic [DEPTH-1:0][XLEN-1:0] wk1_data_s;
    logic [DEPTH-1:0][XLEN-1:0] wk2_data_s;
    logic [DEPTH-1:0]           wk1_rdy_s;
    logic [DEPTH-1:0]           wk2_rdy_s;
    logic [XLEN-1:0]            fwd1_data_s;
    logic [XLEN-1:0]            fwd2_data_s;
    logic                       fwd1_rdy_s;
    logic                       fwd2_rdy_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_operand_wakeup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_wake_op1 (
            .in_data   (entries_r[g].op1.data),
            .in_tag    (entries_r[g].op1.tag),
            .in_rdy    (entries_r[g].op1.rdy),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .out_data  (wk1_data_s[g]),
            .out_rdy   (wk1_rdy_s[g])
        );
        iq_operand_wakeup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_wake_op2 (
            .in_data   (entries_r[g].op2.data),
            .in_tag    (entries_r[g].op2.tag),
            .in_rdy    (entries_r[g].op2.rdy),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_data),
            .out_data  (wk2_data_s[g]),
            .out_rdy   (wk2_rdy_s[g])
        );
    end

    // Forward a same-cycle broadcast into the incoming operands so it is not lost
    iq_operand_wakeup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_fwd_op1 (
        .in_data   (queue_op1_data),
        .in_tag    (queue_op1_tag),
        .in_rdy    (queue_op1_data_valid),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .out_data  (fwd1_data_s),
        .out_rdy   (fwd1_rdy_s)
    );
    iq_operand_wakeup #(.TAG_W(TAG_W), .XLEN(XLEN)) u_fwd_op2 (
        .in_data   (queue_op2_data),
        .in_tag    (queue_op2_tag),
        .in_rdy    (queue_op2_data_valid),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .out_data  (fwd2_data_s),
        .out_rdy   (fwd2_rdy_s)
    );

    // Assemble the incoming entry from the dispatch port
    always_comb begin
        disp_entry_s          = '0;
        disp_entry_s.valid    = 1'b1;
        disp_entry_s.op1.data = fwd1_data_s;
        disp_entry_s.op1.tag  = queue_op1_tag;
        disp_entry_s.op1.rdy  = fwd1_rdy_s;
        disp_entry_s.op2.data = fwd2_data_s;
        disp_entry_s.op2.tag  = queue_op2_tag;
        disp_entry_s.op2.rdy  = fwd2_rdy_s;
        disp_entry_s.rd_tag   = queue_rd_tag;
        disp_entry_s.funct3   = queue_funct3;
        disp_entry_s.alu_ext  = queue_alu_ext;
    end

    // Stored entries after wakeup; the extra top slot feeds zeros into the collapse
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken_ext_s[i]          = entries_r[i];
            woken_ext_s[i].op1.data = wk1_data_s[i];
            woken_ext_s[i].op1.rdy  = wk1_rdy_s[i];
            woken_ext_s[i].op2.data = wk2_data_s[i];
            woken_ext_s[i].op2.rdy  = wk2_rdy_s[i];
        end
        woken_ext_s[DEPTH] = '0;
    end

    // Oldest-first select: scanning downward leaves the lowest ready index
    always_comb begin
        sel_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready_s[i] = iq_entry_ready(entries_r[i]);
            sel_s      = ready_s[i] ? IDX_W'(i) : sel_s;
        end
    end

    assign any_ready_s   = |ready_s;
    assign sel_entry_s   = entries_r[sel_s];
    assign full_s        = (count_r == CNT_W'(DEPTH));
    assign q_fire_s      = any_ready_s & issue_ready;
    assign disp_accept_s = queue_alu_en & ~full_s;
    assign disp_write_s  = disp_accept_s & ~bypass_s;

`ifdef ALU_IQ_BYPASS_EN
    assign bypass_s = ~any_ready_s & disp_accept_s & fwd1_rdy_s & fwd2_rdy_s
                    & issue_ready & ~flush;
`else
    assign bypass_s = 1'b0;
`endif

    assign wr_idx_s    = count_r - {{(CNT_W-1){1'b0}}, q_fire_s};
    assign count_nxt_s = wr_idx_s + {{(CNT_W-1){1'b0}}, disp_write_s};

    // Collapse above the issued slot, then place the new entry at the tail
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_nxt_s[i] = (q_fire_s && (IDX_W'(i) >= sel_s)) ? woken_ext_s[i+1]
                                                                 : woken_ext_s[i];
            entries_nxt_s[i] = (disp_write_s && (wr_idx_s == CNT_W'(i))) ? disp_entry_s
                                                                         : entries_nxt_s[i];
        end
    end

    // Entry storage and occupancy; flush discards everything pending this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            count_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            count_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= entries_nxt_s[i];
            end
            count_r <= count_nxt_s;
        end
    end

    assign alu_queue_full = full_s;

    // Issue port: queued oldest-ready entry, else a bypassed dispatch, else zeros
    always_comb begin
        issue_valid   = 1'b0;
        issue_op1     = '0;
        issue_op2     = '0;
        issue_rd_tag  = '0;
        issue_funct3  = 3'b000;
        issue_alu_ext = 3'b000;
        if (any_ready_s) begin
            issue_valid   = 1'b1;
            issue_op1     = sel_entry_s.op1.data;
            issue_op2     = sel_entry_s.op2.data;
            issue_rd_tag  = sel_entry_s.rd_tag;
            issue_funct3  = sel_entry_s.funct3;
            issue_alu_ext = sel_entry_s.alu_ext;
        end else if (bypass_s) begin
            issue_valid   = 1'b1;
            issue_op1     = disp_entry_s.op1.data;
            issue_op2     = disp_entry_s.op2.data;
            issue_rd_tag  = disp_entry_s.rd_tag;
            issue_funct3  = disp_entry_s.funct3;
            issue_alu_ext = disp_entry_s.alu_ext;
        end else begin
            issue_valid   = 1'b0;
            issue_op1     = '0;
            issue_op2     = '0;
            issue_rd_tag  = '0;
            issue_funct3  = 3'b000;
            issue_alu_ext = 3'b000;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue (default build, no bypass).
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             queue_alu_en;
    logic [XLEN-1:0]  queue_op1_data;
    logic [TAG_W-1:0] queue_op1_tag;
    logic             queue_op1_data_valid;
    logic [XLEN-1:0]  queue_op2_data;
    logic [TAG_W-1:0] queue_op2_tag;
    logic             queue_op2_data_valid;
    logic [TAG_W-1:0] queue_rd_tag;
    logic [2:0]       queue_funct3;
    logic [2:0]       queue_alu_ext;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             alu_queue_full;
    logic             issue_valid;
    logic             issue_ready;
    logic [XLEN-1:0]  issue_op1;
    logic [XLEN-1:0]  issue_op2;
    logic [TAG_W-1:0] issue_rd_tag;
    logic [2:0]       issue_funct3;
    logic [2:0]       issue_alu_ext;

    typedef struct packed {
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [TAG_W-1:0] rd;
        logic [2:0]       f3;
        logic [2:0]       ext;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    int   p0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .queue_alu_en         (queue_alu_en),
        .queue_op1_data       (queue_op1_data),
        .queue_op1_tag        (queue_op1_tag),
        .queue_op1_data_valid (queue_op1_data_valid),
        .queue_op2_data       (queue_op2_data),
        .queue_op2_tag        (queue_op2_tag),
        .queue_op2_data_valid (queue_op2_data_valid),
        .queue_rd_tag         (queue_rd_tag),
        .queue_funct3         (queue_funct3),
        .queue_alu_ext        (queue_alu_ext),
        .cdb_valid            (cdb_valid),
        .cdb_tag              (cdb_tag),
        .cdb_data             (cdb_data),
        .alu_queue_full       (alu_queue_full),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .issue_op1            (issue_op1),
        .issue_op2            (issue_op2),
        .issue_rd_tag         (issue_rd_tag),
        .issue_funct3         (issue_funct3),
        .issue_alu_ext        (issue_alu_ext)
    );

    // Scoreboard: each accepted handshake must match the next expected issue
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_issue got rd_tag=%0h op1=%0h, expected no issue",
                         issue_rd_tag, issue_op1);
            end else begin
                mon_e = sb.pop_front();
                if ({issue_op1, issue_op2, issue_rd_tag, issue_funct3, issue_alu_ext} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_issue got op1=%0h op2=%0h rd=%0h f3=%0h ext=%0h, expected op1=%0h op2=%0h rd=%0h f3=%0h ext=%0h",
                             issue_op1, issue_op2, issue_rd_tag, issue_funct3, issue_alu_ext,
                             mon_e.op1, mon_e.op2, mon_e.rd, mon_e.f3, mon_e.ext);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        flush                = 1'b0;
        queue_alu_en         = 1'b0;
        queue_op1_data       = '0;
        queue_op1_tag        = '0;
        queue_op1_data_valid = 1'b0;
        queue_op2_data       = '0;
        queue_op2_tag        = '0;
        queue_op2_data_valid = 1'b0;
        queue_rd_tag         = '0;
        queue_funct3         = 3'd0;
        queue_alu_ext        = 3'd0;
        cdb_valid            = 1'b0;
        cdb_tag              = '0;
        cdb_data             = '0;
    endtask

    task automatic disp(input logic [31:0] d1, input logic v1, input logic [5:0] t1,
                        input logic [31:0] d2, input logic v2, input logic [5:0] t2,
                        input logic [5:0] rd, input logic [2:0] f3, input logic [2:0] ext);
        queue_alu_en         = 1'b1;
        queue_op1_data       = d1;
        queue_op1_data_valid = v1;
        queue_op1_tag        = t1;
        queue_op2_data       = d2;
        queue_op2_data_valid = v2;
        queue_op2_tag        = t2;
        queue_rd_tag         = rd;
        queue_funct3         = f3;
        queue_alu_ext        = ext;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [5:0] rd,
                        input logic [2:0] f3, input logic [2:0] ext);
        sb.push_back({o1, o2, rd, f3, ext});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        issue_ready = 1'b1;
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got %b expected 0", issue_valid); end
        checks++; if (alu_queue_full !== 1'b0) begin failures++; $display("FAIL reset_full got %b expected 0", alu_queue_full); end
        checks++; if (issue_op1 !== 32'h0 || issue_rd_tag !== 6'h0) begin failures++; $display("FAIL reset_outputs got op1=%0h rd=%0h expected 0", issue_op1, issue_rd_tag); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        issue_ready = 1'b1;
        tick();
        disp(32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd5, 3'd3, 3'd1);
        push(32'd1, 32'd2, 6'd5, 3'd3, 3'd1);
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL single_no_zero_latency got %b expected 0", issue_valid); end
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_op1 !== 32'd1 || issue_op2 !== 32'd2) begin failures++; $display("FAIL single_issue got v=%b op1=%0h op2=%0h expected 1/1/2", issue_valid, issue_op1, issue_op2); end
        tick();
        sample();
        checks++; if (issue_valid !== 1'b0 || alu_queue_full !== 1'b0) begin failures++; $display("FAIL single_empty got v=%b full=%b expected 0/0", issue_valid, alu_queue_full); end
    endtask

    task automatic test_wakeup();
        issue_ready = 1'b1;
        tick();
        disp(32'hDEAD, 1'b0, 6'd3, 32'd4, 1'b1, 6'd0, 6'd6, 3'd1, 3'd2);
        push(32'h24, 32'd4, 6'd6, 3'd1, 3'd2);
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_pending got %b expected 0", issue_valid); end
        tick();
        cdb(6'd3, 32'h24);
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got %b expected 0", issue_valid); end
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_op1 !== 32'h24) begin failures++; $display("FAIL wake_issue got v=%b op1=%0h expected 1/24", issue_valid, issue_op1); end
        // Tag zero wakes like any other tag
        tick();
        disp(32'd5, 1'b1, 6'd0, 32'hBEEF, 1'b0, 6'd0, 6'd7, 3'd2, 3'd3);
        push(32'd5, 32'h55, 6'd7, 3'd2, 3'd3);
        tick();
        idle();
        cdb(6'd0, 32'h55);
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_tag0_pending got %b expected 0", issue_valid); end
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_op2 !== 32'h55) begin failures++; $display("FAIL wake_tag0_issue got v=%b op2=%0h expected 1/55", issue_valid, issue_op2); end
        tick();
    endtask

    task automatic test_dispatch_cdb();
        issue_ready = 1'b1;
        tick();
        disp(32'd7, 1'b1, 6'd0, 32'hBAD, 1'b0, 6'h0A, 6'd9, 3'd4, 3'd0);
        cdb(6'h0A, 32'd10);
        push(32'd7, 32'd10, 6'd9, 3'd4, 3'd0);
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_op2 !== 32'd10) begin failures++; $display("FAIL fwd_issue got v=%b op2=%0h expected 1/a", issue_valid, issue_op2); end
        tick();
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL fwd_empty got %b expected 0", issue_valid); end
    endtask

    task automatic test_full();
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            disp(32'(i * 16), 1'b1, 6'd0, 32'(i * 16 + 1), 1'b1, 6'd0, 6'(i), 3'(i), 3'(7 - i));
            push(32'(i * 16), 32'(i * 16 + 1), 6'(i), 3'(i), 3'(7 - i));
        end
        tick();
        idle();
        sample();
        checks++; if (alu_queue_full !== 1'b1) begin failures++; $display("FAIL full_flag got %b expected 1", alu_queue_full); end
        checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'd1) begin failures++; $display("FAIL full_hold got v=%b rd=%0h expected 1/1", issue_valid, issue_rd_tag); end
        tick();
        disp(32'hEE, 1'b1, 6'd0, 32'hEF, 1'b1, 6'd0, 6'h3F, 3'd0, 3'd0);
        sample();
        checks++; if (alu_queue_full !== 1'b1) begin failures++; $display("FAIL full_ignore got %b expected 1", alu_queue_full); end
        // Dispatch while full is refused even though an issue happens this cycle
        tick();
        disp(32'hCC, 1'b1, 6'd0, 32'hCD, 1'b1, 6'd0, 6'h3E, 3'd0, 3'd0);
        issue_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                idle();
            end
            sample();
            checks++; if (pops !== p0 + k + 1) begin failures++; $display("FAIL full_drain_rate got %0d issues expected %0d", pops - p0, k + 1); end
        end
        tick();
        sample();
        checks++; if (issue_valid !== 1'b0 || alu_queue_full !== 1'b0) begin failures++; $display("FAIL full_drained got v=%b full=%b expected 0/0", issue_valid, alu_queue_full); end
    endtask

    task automatic test_age_order();
        issue_ready = 1'b0;
        tick();
        disp(32'h0, 1'b0, 6'd7, 32'd1, 1'b1, 6'd0, 6'h0A, 3'd5, 3'd1);
        tick();
        disp(32'd2, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 6'h0B, 3'd6, 3'd2);
        push(32'd2, 32'd3, 6'h0B, 3'd6, 3'd2);
        push(32'h77, 32'd1, 6'h0A, 3'd5, 3'd1);
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'h0B) begin failures++; $display("FAIL age_younger_first got v=%b rd=%0h expected 1/b", issue_valid, issue_rd_tag); end
        tick();
        issue_ready = 1'b1;
        cdb(6'd7, 32'h77);
        sample();
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'h0A || issue_op1 !== 32'h77) begin failures++; $display("FAIL age_woken got v=%b rd=%0h op1=%0h expected 1/a/77", issue_valid, issue_rd_tag, issue_op1); end
        tick();
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL age_empty got %b expected 0", issue_valid); end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            tick();
            disp(32'(100 + i), 1'b1, 6'd0, 32'(200 + i), 1'b1, 6'd0, 6'(32 + i), 3'(i), 3'(i + 1));
            push(32'(100 + i), 32'(200 + i), 6'(32 + i), 3'(i), 3'(i + 1));
            sample();
            checks++; if (issue_valid !== (i > 0)) begin failures++; $display("FAIL b2b_overlap[%0d] got %b expected %b", i, issue_valid, (i > 0)); end
        end
        tick();
        idle();
        sample();
        tick();
        sample();
        checks++; if (pops !== p0 + 5 || issue_valid !== 1'b0) begin failures++; $display("FAIL b2b_count got %0d issues v=%b expected 5/0", pops - p0, issue_valid); end
    endtask

    task automatic test_flush_reset();
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            disp(32'(300 + i), 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'(48 + i), 3'd0, 3'd0);
        end
        tick();
        disp(32'd400, 1'b0, 6'd5, 32'd1, 1'b1, 6'd0, 6'h33, 3'd0, 3'd0);
        cdb(6'd5, 32'h99);
        flush = 1'b1;
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b0 || alu_queue_full !== 1'b0 || issue_op1 !== 32'h0) begin failures++; $display("FAIL flush_clear got v=%b full=%b op1=%0h expected 0/0/0", issue_valid, alu_queue_full, issue_op1); end
        issue_ready = 1'b1;
        p0 = pops;
        tick();
        sample();
        checks++; if (pops !== p0 || issue_valid !== 1'b0) begin failures++; $display("FAIL flush_stays_empty got %0d issues v=%b expected 0/0", pops - p0, issue_valid); end
        issue_ready = 1'b0;
        tick();
        disp(32'd500, 1'b1, 6'd0, 32'd501, 1'b1, 6'd0, 6'h34, 3'd1, 3'd1);
        tick();
        disp(32'd502, 1'b1, 6'd0, 32'd503, 1'b1, 6'd0, 6'h35, 3'd1, 3'd1);
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL rst_pre got %b expected 1", issue_valid); end
        rst = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0 || issue_op1 !== 32'h0 || issue_rd_tag !== 6'h0 || alu_queue_full !== 1'b0) begin failures++; $display("FAIL rst_async got v=%b op1=%0h rd=%0h full=%b expected all 0", issue_valid, issue_op1, issue_rd_tag, alu_queue_full); end
        tick();
        rst = 1'b0;
        issue_ready = 1'b1;
        sample();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rst_discard got %b expected 0", issue_valid); end
        tick();
        disp(32'd600, 1'b1, 6'd0, 32'd601, 1'b1, 6'd0, 6'h36, 3'd2, 3'd5);
        push(32'd600, 32'd601, 6'h36, 3'd2, 3'd5);
        tick();
        idle();
        sample();
        checks++; if (issue_valid !== 1'b1 || issue_rd_tag !== 6'h36) begin failures++; $display("FAIL rst_recover got v=%b rd=%0h expected 1/36", issue_valid, issue_rd_tag); end
        tick();
        sample();
    endtask

    initial begin
        issue_ready = 1'b0;
        test_reset();
        test_single();
        test_wakeup();
        test_dispatch_cdb();
        test_full();
        test_age_order();
        test_back_to_back();
        test_flush_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Integer ALU reservation station, directly downstream of the Tomasulo front-end cluster.
- Accepts ALU dispatches (operands with tag or data, destination tag, funct3, alu_ext).
- Snoops the CDB to wake pending operands.
- Issues the oldest ready entry to the ALU through a valid/ready handshake, and signals full back to dispatch.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- TAG_W, 6, CDB/ROB tag width.
- XLEN, 32, operand data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous: invalidate all entries (branch abort).
- queue_alu_en  in  1  dispatch write strobe.
- queue_op1_data  in  XLEN  op1 value.
- queue_op1_tag  in  TAG_W  op1 producer tag.
- queue_op1_data_valid  in  1  1 = op1 data present.
- queue_op2_data  in  XLEN  op2 value.
- queue_op2_tag  in  TAG_W  op2 producer tag.
- queue_op2_data_valid  in  1  1 = op2 data present.
- queue_rd_tag  in  TAG_W  destination tag.
- queue_funct3  in  3  ALU funct3.
- queue_alu_ext  in  3  ALU extension bits.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_data  in  XLEN  CDB result.
- alu_queue_full  out  1  count == DEPTH.
- issue_valid  out  1  ready entry presented.
- issue_ready  in  1  ALU accepts this cycle.
- issue_op1  out  XLEN  op1 of issued entry.
- issue_op2  out  XLEN  op2 of issued entry.
- issue_rd_tag  out  TAG_W  destination tag.
- issue_funct3  out  3  funct3.
- issue_alu_ext  out  3  alu_ext.

Behaviour:
- Reset (async, rst=1): all entry valid bits 0, count 0; alu_queue_full=0, issue_valid=0; issue data outputs 0 while issue_valid=0.
- Storage: age-ordered collapsing array; slot 0 is oldest. Entry fields: valid, op1/op2 {data, tag, rdy}, rd_tag, funct3, alu_ext.
- Dispatch: on queue_alu_en=1 and not full, write to slot count (after collapse) at the clock edge.
  - queue_alu_en while full is a dispatcher error: ignored, no state change.
- Wakeup: for each valid entry operand with rdy=0, if cdb_valid and cdb_tag equals the stored tag, capture cdb_data and set rdy at the edge.
  - Tag 0 is a legal tag.
- Dispatch/CDB same cycle: an incoming operand with data_valid=0 whose tag matches the live CDB is written with cdb_data and rdy=1; the wakeup is not lost.
- Select: issue_valid=1 when any valid entry has both operands rdy. Outputs are combinational from the lowest-index ready entry.
- Handshake:
  - On issue_valid & issue_ready, the selected entry is removed.
  - Younger entries shift down one slot in the same edge.
  - Holds until accepted. Outputs are stable while issue_valid=1 and issue_ready=0, unless an older entry becomes ready (oldest-first wins).
- Latency: dispatch with both operands ready gives issue_valid the next cycle (1-cycle minimum). A CDB wakeup gives issue_valid the cycle after the broadcast.
- Issue + dispatch same cycle: both take effect. The new entry lands at slot count-1 after collapse. Count is unchanged.
- Full boundary: alu_queue_full is combinational from registered count. A dispatch while full is not accepted even if an issue occurs in the same cycle.
- Flush: at the edge, clears all valid bits and count. It overrides dispatch, issue removal and wakeup in that cycle.
- Reset mid-operation: all pending entries are discarded immediately (async); no issue occurs after rst asserts.

Optional Feature:
- Macro: ALU_IQ_BYPASS_EN.
- Defined: if no queued entry is ready, and the dispatch this cycle has both operands ready (including the CDB forward), and issue_ready=1, then:
  - the instruction issues combinationally in the same cycle (0-cycle latency);
  - it is not written into the queue.
  - If issue_ready=0, it is written normally.
- Undefined: no bypass; 1-cycle minimum latency.

Decomposition:
- Package alu_iq_pkg:
  - constants IQ_TAG_W=6 and IQ_XLEN=32;
  - typedef iq_operand_t {data, tag, rdy};
  - typedef iq_entry_t {valid, op1, op2, rd_tag, funct3, alu_ext}.
- Sub-module iq_operand_wakeup: one operand's CDB compare and capture. It is instantiated 2×DEPTH times, plus 2 on the dispatch forward path.

Test Plan:
1. Dispatch op1=1, op2=2 (both valid), rd_tag=5, issue_ready=1 -> next cycle issue_valid=1, issue_op1=1, issue_op2=2, issue_rd_tag=5; queue empty afterwards.
2. Dispatch op1 tag=3 (not valid), op2=4; two cycles later CDB tag=3, data=0x24 -> issue_valid=1 the following cycle with issue_op1=0x24.
3. Dispatch with op2 tag=0x0A not valid, same cycle CDB valid tag=0x0A, data=10 -> entry captured ready; issues next cycle with op2=10.
4. issue_ready=0, dispatch 4 ready entries -> alu_queue_full=1; fifth dispatch ignored; with issue_ready=1, entries issue in dispatch order, 1 per cycle.
5. Entry A (pending tag 7) then B (ready) -> B issues first; CDB tag 7 -> A issues next; order reported as B, A.
6. Queue holding 3 entries, flush=1 coincident with dispatch and CDB -> count=0, issue_valid=0 next cycle. Repeat with rst pulsed mid-stream -> outputs 0 immediately.
